// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational adder among
// NUM_REQ requesters and returns a registered, requester-tagged sum.
module adder_share_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned IDW     = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    input  logic [NUM_REQ-1:0]         req_cin,
    output logic [WIDTH-1:0]           add_x,
    output logic [WIDTH-1:0]           add_y,
    output logic                       add_cin,
    input  logic [WIDTH-1:0]           add_s,
    input  logic                       add_cout,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [IDW-1:0]             rsp_id,
    output logic [WIDTH-1:0]           rsp_sum,
    output logic                       rsp_cout
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;

    logic             hi_hit;
    logic [IDW-1:0]   hi_idx, lo_idx;
    logic             grant_vld_c;
    logic [IDW-1:0]   grant_idx_c;
    logic             can_accept_c;
    logic             accept_c;
    logic [IDW-1:0]   sel_c;

    // First valid index at/after rr_ptr; otherwise the lowest valid one (wrap-around).
    always_comb begin
        hi_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_idx = IDW'(i);
                if (IDW'(i) >= rr_ptr_q) begin
                    hi_hit = 1'b1;
                    hi_idx = IDW'(i);
                end
            end
        end
        grant_vld_c = |req_valid;
        grant_idx_c = hi_hit ? hi_idx : lo_idx;
    end

    assign can_accept_c = (state_q == IDLE) || rsp_ready;
    assign accept_c     = grant_vld_c && can_accept_c;
    assign sel_c        = grant_vld_c ? grant_idx_c : rr_ptr_q;

    // Handshake and operand steering must be combinational so the add completes in the grant cycle.
    always_comb begin
        req_ready = '0;
        add_x     = '0;
        add_y     = '0;
        add_cin   = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_ready[i] = rst_n && accept_c && (grant_idx_c == IDW'(i));
            if (sel_c == IDW'(i)) begin
                add_x   = req_a[i*WIDTH +: WIDTH];
                add_y   = req_b[i*WIDTH +: WIDTH];
                add_cin = req_cin[i];
            end
        end
    end

    // Next state: capture on accept, drain to IDLE when consumed with nothing new.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        rsp_id_d   = rsp_id_q;
        rsp_sum_d  = rsp_sum_q;
        rsp_cout_d = rsp_cout_q;
        if (accept_c) begin
            state_d    = HOLD;
            rsp_id_d   = grant_idx_c;
            rsp_sum_d  = add_s;
            rsp_cout_d = add_cout;
            rr_ptr_d   = (grant_idx_c == IDW'(NUM_REQ - 1)) ? '0 : grant_idx_c + IDW'(1);
        end else if (rsp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            rsp_id_q   <= '0;
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            rsp_id_q   <= rsp_id_d;
            rsp_sum_q  <= rsp_sum_d;
            rsp_cout_q <= rsp_cout_d;
        end
    end

    assign rsp_valid = (state_q == HOLD);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;

endmodule
